md5_msg_builder: RTL and testbench
==================================

Name: md5_msg_builder

Overview:
- Producer side of the MD5 hash datapath for the password-cracking engine.
- Walks a decimal candidate range, renders each candidate as ASCII digits, and applies MD5 padding and the length field.
- Streams each 512-bit block to the hash core as 16 little-endian 32-bit words over a valid/ready handshake.
- Replaces ad-hoc message assembly inside the hash core; the hash core becomes a pure word consumer.

Parameters:
- NUM_DIGITS, 8: candidate width in decimal digits; legal range 1..16.
- CNT_W, 32: width of the accepted-block counter.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle pulse; loads the range and begins; ignored unless the FSM is in IDLE or DONE
- abort_i  input  1  stops immediately (hash core found a match)
- start_bcd_i  input  4*NUM_DIGITS  first candidate, packed BCD, MSD in the top nibble
- end_bcd_i  input  4*NUM_DIGITS  last candidate, inclusive, packed BCD
- word_o  output  32  message word
- word_idx_o  output  4  index of word_o within the block, 0..15
- word_valid_o  output  1  word_o is valid
- word_last_o  output  1  high with word 15
- word_ready_i  input  1  consumer accepts the current word
- cand_bcd_o  output  4*NUM_DIGITS  candidate of the block currently being emitted
- blk_cnt_o  output  CNT_W  number of blocks fully accepted since start_i
- busy_o  output  1  FSM is in EMIT or NEXT
- done_o  output  1  range finished or rejected; held until the next start_i
- err_o  output  1  illegal BCD nibble (>9) in start_bcd_i or end_bcd_i at start_i

Behaviour:
- Reset state: all outputs 0, FSM in IDLE. Reset is asynchronous and active-low and may assert mid-block; the partial block is discarded with no recovery.
- FSM states: IDLE, EMIT, NEXT, DONE.
- IDLE/DONE on start_i:
  - Clears blk_cnt_o, done_o and err_o.
  - Any nibble >9 in either input: go to DONE with err_o=1.
  - start_bcd_i > end_bcd_i (plain unsigned compare): go to DONE, no blocks emitted.
  - Otherwise: cnt <= start_bcd_i, widx <= 0, go to EMIT.
  - Latency: word_valid_o is high in the cycle after start_i.
- EMIT:
  - word_valid_o=1 and word_o = block word widx.
  - word_o, word_idx_o and cand_bcd_o hold stable while word_ready_i is low.
  - On valid&&ready: widx increments.
  - On valid&&ready with widx=15: blk_cnt_o increments and the FSM goes to NEXT.
- NEXT (one-cycle bubble, word_valid_o=0):
  - cnt == end_bcd_i: go to DONE, done_o=1.
  - Otherwise: cnt <= BCD increment of cnt (per-digit carry), widx <= 0, go to EMIT.
  - Range end at all 9s terminates; the counter never wraps.
- abort_i has priority over everything in any state:
  - Next cycle: IDLE, word_valid_o=0, done_o=0.
  - cand_bcd_o and blk_cnt_o keep their values.
- Block layout: message byte j sits in word j/4, bits [8*(j%4)+7 : 8*(j%4)].
  - Bytes 0..L-1: ASCII 0x30+digit, MSD first.
  - Byte L: 0x80.
  - Bytes 56..63: bit length 8*L, 64-bit little-endian.
  - All other bytes 0x00.
- Default message length is fixed: L = NUM_DIGITS, leading zeros included.
- Word contents are computed combinationally from cnt and widx and registered onto word_o.

Optional Feature:
- Macro: MD5_MSG_BUILDER_VARLEN_EN.
- Defined: leading zeros are stripped. L = number of significant digits (minimum 1, so zero renders as "0"). The digit bytes, 0x80 position and length field follow L.
- Undefined: fixed length L = NUM_DIGITS as above.

Decomposition:
- md5_pkg holds:
  - MD5_WORDS_PER_BLK=16
  - ASCII_ZERO=8'h30
  - MD5_PAD_BYTE=8'h80
  - MD5_LEN_BYTE_OFS=56
  - builder state enum
- Sub-module md5_bcd_counter: NUM_DIGITS-digit BCD register with load, increment (ripple carry), equal-compare to a bound, and a leading-zero count (used by VARLEN).

Test Plan:
- Fixed length, NUM_DIGITS=8, start=end=00000000, ready tied 1:
  - word0=0x30303030, word1=0x30303030, word2=0x00000080, word14=0x00000040, word15=0.
  - done_o=1 and blk_cnt_o=1.
- start=end=31415926: word0=0x31343133, word1=0x36323935, word2=0x00000080.
- Range 00000098..00000101 with ready toggling 1/0 every cycle:
  - Exactly 4 blocks, with cand_bcd_o = 98, 99, 100, 101 in order.
  - word_o held stable whenever ready is low.
  - blk_cnt_o=4.
- VARLEN enabled, start=end=00000042: word0=0x00803234, word14=0x00000010, all other words 0.
- Error and empty range:
  - start=0000000A: err_o=1 and done_o=1 with no word_valid_o.
  - start=00000005 with end=00000003: done_o=1, blk_cnt_o=0.
- Abort and reset mid-stream:
  - abort_i asserted during word 7 of the 3rd block: word_valid_o=0 next cycle, blk_cnt_o=2, FSM in IDLE.
  - reset_n asserted low mid-EMIT: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/md5_pkg.sv
// -----------------------------------------------------------------------------
// md5_pkg
// Shared constants and types for the MD5 message builder datapath.
//   MD5_WORDS_PER_BLK  : 32-bit words per 512-bit MD5 block
//   ASCII_ZERO         : ASCII code of the digit '0'
//   MD5_PAD_BYTE       : first padding byte following the message
//   MD5_LEN_BYTE_OFS   : byte offset of the 64-bit little-endian bit length
//   LZ_W               : width of a leading-zero count (candidates up to 16 digits)
//   builder_state_e    : message builder FSM states
// -----------------------------------------------------------------------------
package md5_pkg;

    localparam int         MD5_WORDS_PER_BLK = 16;
    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] MD5_PAD_BYTE      = 8'h80;
    localparam int         MD5_LEN_BYTE_OFS  = 56;
    localparam int         LZ_W              = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_NEXT,
        ST_DONE
    } builder_state_e;

endpackage

// File: rtl/md5_bcd_counter.sv
// -----------------------------------------------------------------------------
// md5_bcd_counter
// NUM_DIGITS-digit packed-BCD register (MSD in the top nibble).
//   clk, reset_n     : clock, asynchronous active-low reset
//   load, load_val   : load a new value (has priority over inc)
//   inc              : add one with per-digit ripple carry
//   bound            : value compared against for at_bound
//   value            : registered counter value
//   value_next       : value the register takes at the next edge
//   at_bound         : value == bound
//   next_lead_zeros  : leading zero digits of value_next
// -----------------------------------------------------------------------------
module md5_bcd_counter
    import md5_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    inc,
    input  logic [4*NUM_DIGITS-1:0] bound,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [4*NUM_DIGITS-1:0] value_next,
    output logic                    at_bound,
    output logic [LZ_W-1:0]         next_lead_zeros
);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [4*NUM_DIGITS-1:0] inc_val;
    logic                    carry;
    logic                    seen_nz;

    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        inc_val = value_q;
        carry   = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (value_q[4*d +: 4] == 4'd9) begin
                    inc_val[4*d +: 4] = 4'd0;
                end else begin
                    inc_val[4*d +: 4] = value_q[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    assign value_next = load ? load_val : (inc ? inc_val : value_q);

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_next;
        end
    end

    // Counted on the next value because that is what the word renderer sees.
    always_comb begin
        next_lead_zeros = '0;
        seen_nz         = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (value_next[4*d +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end else if (!seen_nz) begin
                next_lead_zeros = next_lead_zeros + LZ_W'(1);
            end
        end
    end

    assign value    = value_q;
    assign at_bound = (value_q == bound);

endmodule

// File: rtl/md5_msg_builder.sv
// -----------------------------------------------------------------------------
// md5_msg_builder
// Walks a decimal candidate range, renders each candidate as ASCII digits,
// applies MD5 padding plus bit length, and streams each 512-bit block as 16
// little-endian 32-bit words over valid/ready.
// Build option: define MD5_MSG_BUILDER_VARLEN_EN to strip leading zeros
// (message length = significant digits, minimum 1); otherwise the message
// length is always NUM_DIGITS.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   start_i, abort_i            : begin a range / stop at once
//   start_bcd_i, end_bcd_i      : inclusive candidate range, packed BCD
//   word_o, word_idx_o          : message word and its index in the block
//   word_valid_o, word_last_o   : word valid, last word of the block
//   word_ready_i                : consumer accepts the current word
//   cand_bcd_o                  : candidate of the block being emitted
//   blk_cnt_o                   : blocks fully accepted since start_i
//   busy_o, done_o, err_o       : status
// -----------------------------------------------------------------------------
module md5_msg_builder
    import md5_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [4*NUM_DIGITS-1:0] start_bcd_i,
    input  logic [4*NUM_DIGITS-1:0] end_bcd_i,
    output logic [31:0]             word_o,
    output logic [3:0]              word_idx_o,
    output logic                    word_valid_o,
    output logic                    word_last_o,
    input  logic                    word_ready_i,
    output logic [4*NUM_DIGITS-1:0] cand_bcd_o,
    output logic [CNT_W-1:0]        blk_cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int         BCD_W    = 4 * NUM_DIGITS;
    localparam logic [3:0] LAST_IDX = 4'(MD5_WORDS_PER_BLK - 1);

    function automatic logic bcd_legal(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    builder_state_e    state_q, state_d;
    logic [3:0]        widx_q, widx_d;
    logic [BCD_W-1:0]  end_q;
    logic [BCD_W-1:0]  cnt_q, cnt_next;
    logic              cnt_load, cnt_inc, at_end;
    logic [LZ_W-1:0]   lead_zeros, msg_len;
    logic              start_take, bad_bcd, accept, blk_inc;
    logic [31:0]       word_d, word_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic              err_q;
    int                byte_pos, dig_pos;
    logic [3:0]        digit;
    logic [7:0]        byte_val;

    assign bad_bcd    = !bcd_legal(start_bcd_i) || !bcd_legal(end_bcd_i);
    assign start_take = start_i && !abort_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept     = (state_q == ST_EMIT) && word_ready_i;
    assign blk_inc    = accept && !abort_i && (widx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (bad_bcd || (start_bcd_i > end_bcd_i)) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_load = 1'b1;
                            widx_d   = '0;
                            state_d  = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        widx_d = widx_q + 4'd1;
                        if (widx_q == LAST_IDX) state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // end_q is legal BCD and cnt never passes it, so the increment cannot wrap.
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        widx_d  = '0;
                        state_d = ST_EMIT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    md5_bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_cnt (
        .clk             (clk),
        .reset_n         (reset_n),
        .load            (cnt_load),
        .load_val        (start_bcd_i),
        .inc             (cnt_inc),
        .bound           (end_q),
        .value           (cnt_q),
        .value_next      (cnt_next),
        .at_bound        (at_end),
        .next_lead_zeros (lead_zeros)
    );

`ifdef MD5_MSG_BUILDER_VARLEN_EN
    assign msg_len = (lead_zeros == LZ_W'(NUM_DIGITS)) ? LZ_W'(1)
                                                       : LZ_W'(NUM_DIGITS) - lead_zeros;
`else
    logic unused_lz;
    assign unused_lz = ^lead_zeros;  // lead-zero count only feeds the variable-length renderer
    assign msg_len   = LZ_W'(NUM_DIGITS);
`endif

    // Render the word for the next (candidate, index) pair so it can be
    // registered and presented in the same cycle the FSM enters/stays in EMIT.
    always_comb begin
        word_d   = '0;
        byte_pos = 0;
        dig_pos  = 0;
        digit    = '0;
        byte_val = '0;
        for (int b = 0; b < 4; b++) begin
            byte_pos = 4 * int'(widx_d) + b;
            dig_pos  = NUM_DIGITS - int'(msg_len) + byte_pos;
            digit    = '0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (d == dig_pos) digit = cnt_next[4*(NUM_DIGITS-1-d) +: 4];
            end
            if (byte_pos < int'(msg_len)) begin
                byte_val = ASCII_ZERO + {4'h0, digit};
            end else if (byte_pos == int'(msg_len)) begin
                byte_val = MD5_PAD_BYTE;
            end else if (byte_pos == MD5_LEN_BYTE_OFS) begin
                // At most 16 digits, so 8*L < 256 and the upper length bytes stay zero.
                byte_val = {msg_len, 3'b000};
            end else begin
                byte_val = 8'h00;
            end
            word_d[8*b +: 8] = byte_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            widx_q    <= '0;
            end_q     <= '0;
            word_q    <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            if (cnt_load) end_q <= end_bcd_i;
            if (state_d == ST_EMIT) word_q <= word_d;
            if (start_take) begin
                blk_cnt_q <= '0;
                err_q     <= bad_bcd;
            end else if (blk_inc) begin
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
            end
        end
    end

    assign word_o       = word_q;
    assign word_idx_o   = widx_q;
    assign word_valid_o = (state_q == ST_EMIT);
    assign word_last_o  = word_valid_o && (widx_q == LAST_IDX);
    assign cand_bcd_o   = cnt_q;
    assign blk_cnt_o    = blk_cnt_q;
    assign busy_o       = (state_q == ST_EMIT) || (state_q == ST_NEXT);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_md5_msg_builder.sv
// -----------------------------------------------------------------------------
// tb_md5_msg_builder
// Self-checking bench for md5_msg_builder (NUM_DIGITS = 8). Expected words
// come from a byte-level MD5 message model pushed to a scoreboard queue and
// from a table of hand-computed block words.
// -----------------------------------------------------------------------------
module tb_md5_msg_builder;

    localparam int ND    = 8;
    localparam int CNT_W = 32;

    typedef struct {
        logic [31:0] cand;
        logic [3:0]  idx;
        logic [31:0] word;
    } sb_item_t;

    typedef struct {
        logic [31:0] cand;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [4*ND-1:0]   start_bcd;
    logic [4*ND-1:0]   end_bcd;
    logic [31:0]       word;
    logic [3:0]        word_idx;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic [4*ND-1:0]   cand;
    logic [CNT_W-1:0]  blk_cnt;
    logic              busy;
    logic              done;
    logic              err;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_item_t    sb_q[$];
    logic [31:0] blk_cands[$];
    logic [31:0] cap[16];
    vec_t        vecs[$];
    logic        sb_en     = 1'b1;
    logic        toggle_en = 1'b0;

    md5_msg_builder #(
        .NUM_DIGITS (ND),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .start_bcd_i  (start_bcd),
        .end_bcd_i    (end_bcd),
        .word_o       (word),
        .word_idx_o   (word_idx),
        .word_valid_o (word_valid),
        .word_last_o  (word_last),
        .word_ready_i (word_ready),
        .cand_bcd_o   (cand),
        .blk_cnt_o    (blk_cnt),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [31:0] b);
        int v;
        v = 0;
        for (int d = ND - 1; d >= 0; d--) v = v * 10 + int'(b[4*d +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] int2bcd(input int v);
        logic [31:0] b;
        int          t;
        b = '0;
        t = v;
        for (int d = 0; d < ND; d++) begin
            b[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // Byte-level MD5 single-block message for one candidate.
    function automatic logic [31:0] exp_word(input logic [31:0] c, input int idx);
        logic [7:0]  msg[64];
        logic [63:0] bit_len;
        int          len;
        int          first;
        len   = ND;
        first = 0;
`ifdef MD5_MSG_BUILDER_VARLEN_EN
        first = ND - 1;
        for (int k = ND - 1; k >= 0; k--) begin
            if (c[4*(ND-1-k) +: 4] != 4'd0) first = k;
        end
        len = ND - first;
`endif
        for (int j = 0; j < 64; j++) msg[j] = 8'h00;
        for (int k = 0; k < len; k++) msg[k] = 8'h30 + {4'h0, c[4*(ND-1-(first+k)) +: 4]};
        msg[len] = 8'h80;
        bit_len  = 64'(8 * len);
        for (int i = 0; i < 8; i++) msg[56+i] = bit_len[8*i +: 8];
        return {msg[4*idx+3], msg[4*idx+2], msg[4*idx+1], msg[4*idx]};
    endfunction

    task automatic push_block(input logic [31:0] c);
        sb_item_t it;
        for (int i = 0; i < 16; i++) begin
            it.cand = c;
            it.idx  = 4'(i);
            it.word = exp_word(c, i);
            sb_q.push_back(it);
        end
    endtask

    task automatic push_range(input logic [31:0] s, input logic [31:0] e);
        for (int v = bcd2int(s); v <= bcd2int(e); v++) push_block(int2bcd(v));
    endtask

    task automatic add_vec(input logic [31:0] c, input int idx, input logic [31:0] exp);
        vec_t v;
        v.cand = c;
        v.idx  = idx;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e);
        @(posedge clk); #1;
        start     = 1'b1;
        start_bcd = s;
        end_bcd   = e;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, done, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, word_valid, 0);
        check({tag, "_last"}, word_last, 0);
        check({tag, "_word"}, word, 0);
        check({tag, "_idx"}, word_idx, 0);
        check({tag, "_cand"}, cand, 0);
        check({tag, "_blk_cnt"}, blk_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic run_single(input logic [31:0] c);
        push_block(c);
        pulse_start(c, c);
        check("latency_valid", word_valid, 1);
        check("latency_idx", word_idx, 0);
        wait_done(200, "single_done");
        check("single_blk_cnt", blk_cnt, 1);
        check("single_sb_empty", sb_q.size(), 0);
    endtask

    // Ready generator: tied high, or toggling every cycle.
    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            word_ready = toggle_en ? ~word_ready : 1'b1;
        end
    end

    // Scoreboard monitor: samples on the falling edge, mid-cycle.
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
    logic [31:0] prev_word  = '0, prev_cand = '0;
    logic [3:0]  prev_idx   = '0;
    always @(negedge clk) begin
        sb_item_t it;
        if (rst_n && sb_en) begin
            if (word_valid && word_ready && !abort) begin
                cap[word_idx] = word;
                check("word_last", word_last, (word_idx == 4'd15));
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got word %h idx %0d cand %h, expected none", word, word_idx, cand);
                end else begin
                    it = sb_q.pop_front();
                    check("sb_word", word, it.word);
                    check("sb_idx", word_idx, it.idx);
                    check("sb_cand", cand, it.cand);
                end
                if (word_idx == 4'd15) blk_cands.push_back(cand);
            end
            if (prev_valid && !prev_ready && !prev_abort && word_valid) begin
                check("hold_word", word, prev_word);
                check("hold_idx", word_idx, prev_idx);
                check("hold_cand", cand, prev_cand);
            end
        end
        prev_valid = word_valid && rst_n;
        prev_ready = word_ready;
        prev_abort = abort;
        prev_word  = word;
        prev_idx   = word_idx;
        prev_cand  = cand;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] last_cand;
        logic [31:0] exp_c[4];
        int          found;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        start_bcd = '0;
        end_bcd   = '0;

`ifdef MD5_MSG_BUILDER_VARLEN_EN
        add_vec(32'h00000042, 0,  32'h00803234);
        add_vec(32'h00000042, 1,  32'h00000000);
        add_vec(32'h00000042, 14, 32'h00000010);
        add_vec(32'h00000042, 15, 32'h00000000);
        add_vec(32'h00000000, 0,  32'h00008030);
        add_vec(32'h00000000, 14, 32'h00000008);
`else
        add_vec(32'h00000000, 0,  32'h30303030);
        add_vec(32'h00000000, 1,  32'h30303030);
        add_vec(32'h00000000, 2,  32'h00000080);
        add_vec(32'h00000000, 14, 32'h00000040);
        add_vec(32'h00000000, 15, 32'h00000000);
`endif
        add_vec(32'h31415926, 0,  32'h31343133);
        add_vec(32'h31415926, 1,  32'h36323935);
        add_vec(32'h31415926, 2,  32'h00000080);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven single-candidate blocks, ready tied high
        last_cand = 32'hFFFF_FFFF;
        foreach (vecs[i]) begin
            if (vecs[i].cand != last_cand) begin
                run_single(vecs[i].cand);
                check("done_after_single", done, 1);
                last_cand = vecs[i].cand;
            end
            check($sformatf("vec_%h_w%0d", vecs[i].cand, vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);
        end

        // Range 98..101 crossing a decade boundary, ready toggling
        toggle_en = 1'b1;
        blk_cands.delete();
        push_range(32'h00000098, 32'h00000101);
        pulse_start(32'h00000098, 32'h00000101);
        wait_done(1000, "range_done");
        toggle_en = 1'b0;
        check("range_blk_cnt", blk_cnt, 4);
        check("range_blocks", blk_cands.size(), 4);
        exp_c[0] = 32'h00000098;
        exp_c[1] = 32'h00000099;
        exp_c[2] = 32'h00000100;
        exp_c[3] = 32'h00000101;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("range_cand%0d", i),
                  (i < blk_cands.size()) ? blk_cands[i] : 32'hDEADBEEF, exp_c[i]);
        end
        check("range_sb_empty", sb_q.size(), 0);

        // Illegal BCD in start and in end
        pulse_start(32'h0000000A, 32'h00000010);
        check("err_start_err", err, 1);
        check("err_start_done", done, 1);
        check("err_start_valid", word_valid, 0);
        check("err_start_blk_cnt", blk_cnt, 0);
        pulse_start(32'h00000001, 32'h0000F000);
        check("err_end_err", err, 1);
        check("err_end_done", done, 1);

        // Empty range
        pulse_start(32'h00000005, 32'h00000003);
        check("empty_err", err, 0);
        check("empty_done", done, 1);
        check("empty_valid", word_valid, 0);
        check("empty_blk_cnt", blk_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        check("empty_still_idle", word_valid, 0);

        // Abort during word 7 of the third block
        push_range(32'h00000000, 32'h00000001);
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back('{cand: 32'h00000002, idx: 4'(i), word: exp_word(32'h00000002, i)});
        end
        pulse_start(32'h00000000, 32'h00000009);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (word_valid && blk_cnt == 2 && word_idx == 4'd7) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reached_word7", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", word_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_blk_cnt", blk_cnt, 2);
        check("abort_cand", cand, 32'h00000002);
        check("abort_sb_empty", sb_q.size(), 0);
        run_single(32'h00000007);

        // Asynchronous reset mid-EMIT
        sb_en = 1'b0;
        pulse_start(32'h00000000, 32'h00000009);
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset_valid", word_valid, 1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        sb_en = 1'b1;
        run_single(32'h31415926);
        check("post_reset_w0", cap[0], 32'h31343133);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
